// File: rtl/accumulator_unit_if.sv
// Command/status bundle between the control unit and the accumulator unit.
// The master drives the command; the slave reports the accumulator value and flags.
interface accumulator_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic [2:0]       op;
    logic             enable;
    logic [WIDTH-1:0] data_out;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output data_in, op, enable,
        input  data_out, carry, zero, negative, overflow, busy, done
    );

    modport slave (
        input  data_in, op, enable,
        output data_out, carry, zero, negative, overflow, busy, done
    );
endinterface

// File: rtl/accumulator_unit.sv
// WIDTH-bit accumulator with single-cycle ALU ops and a multi-cycle unsigned
// shift-add multiply guarded by a busy/done handshake.
module accumulator_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    accumulator_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_ADC  = 3'b011,
        OP_SUB  = 3'b100,
        OP_AND  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_COMMIT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    op_e                op;
    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        op        = op_e'(bus.op);
        accept    = bus.enable && (state_q == S_IDLE);
        sum       = {1'b0, acc_q} + {1'b0, bus.data_in}
                  + {{WIDTH{1'b0}}, (op == OP_ADC) && carry_q};
        diff      = {1'b0, acc_q} - {1'b0, bus.data_in};
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        partial_d = partial_q;
        mplier_d  = mplier_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_NOP: ;
                        OP_LOAD: begin
                            acc_d = bus.data_in;
                            ovf_d = 1'b0;
                        end
                        OP_ADD, OP_ADC: begin
                            acc_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            ovf_d   = (acc_q[WIDTH-1] == bus.data_in[WIDTH-1])
                                   && (sum[WIDTH-1] != acc_q[WIDTH-1]);
                        end
                        OP_SUB: begin
                            // Carry is the inverted borrow: set when acc >= data_in.
                            acc_d   = diff[WIDTH-1:0];
                            carry_d = ~diff[WIDTH];
                            ovf_d   = (acc_q[WIDTH-1] != bus.data_in[WIDTH-1])
                                   && (diff[WIDTH-1] != acc_q[WIDTH-1]);
                        end
                        OP_AND: begin
                            acc_d = acc_q & bus.data_in;
                            ovf_d = 1'b0;
                        end
                        OP_SHR: begin
                            acc_d   = acc_q >> 1;
                            carry_d = acc_q[0];
                            ovf_d   = 1'b0;
                        end
                        OP_MUL: begin
                            state_d   = S_MUL;
                            mcand_d   = {{WIDTH{1'b0}}, acc_q};
                            mplier_d  = bus.data_in;
                            partial_d = '0;
                            cnt_d     = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    partial_d = partial_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                acc_d   = partial_q[WIDTH-1:0];
                carry_d = |partial_q[2*WIDTH-1:WIDTH];
                ovf_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the multiply datapath is not reset; it is fully loaded whenever a MUL is accepted.
    always_ff @(posedge clk) begin
        mcand_q   <= mcand_d;
        partial_q <= partial_d;
        mplier_q  <= mplier_d;
    end

    assign bus.data_out = acc_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = (acc_q == '0);
    assign bus.negative = acc_q[WIDTH-1];
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule
